// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shift/rotate unit: operation modes and FSM states.
package shift_pkg;

    // bit0 = direction (0 left, 1 right), bit1 = kind (0 rotate, 1 zero-fill shift)
    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_SRL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step_1.sv
// One-position rotate/shift step; the only datapath network in the unit.
module shift_step_1
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] stepped
);

    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    always_comb begin
        stepped = data;
        case (mode)
            MODE_ROL: stepped = {data[WIDTH-2:0], data[WIDTH-1]};
            MODE_ROR: stepped = {data[0], data[WIDTH-1:1]};
            MODE_SLL: stepped = {data[WIDTH-2:0], 1'b0};
            MODE_SRL: stepped = {1'b0, data[WIDTH-1:1]};
            default:  stepped = data;
        endcase
    end

endmodule

// File: rtl/shift_rot_seq.sv
// Multi-cycle shift/rotate unit: accepts an operand, steps it one bit per clock,
// then holds the result on a valid/ready output until it is taken.
module shift_rot_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    cnt_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] step_data;

    shift_step_1 #(.WIDTH(WIDTH)) u_step (
        .data    (data_q),
        .mode    (mode_q),
        .stepped (step_data)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        cnt_q  <= in_amt;
                        mode_q <= in_mode;
                    end
                end
                BUSY: begin
                    data_q <= step_data;
                    cnt_q  <= cnt_q - AW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = (in_amt == '0) ? DONE : BUSY;
            BUSY:    if (cnt_q == AW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registers only; in_ready never sees in_valid or out_ready.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_shift_rot_seq.sv
// Scoreboard bench: directed WIDTH=8 vectors plus a WIDTH=32 random regression.
module tb_shift_rot_seq;
    import shift_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          amt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] in_data8, out_data8;
    logic [2:0] in_amt8;
    logic [1:0] in_mode8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] in_data32, out_data32;
    logic [4:0]  in_amt32;
    logic [1:0]  in_mode32;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rnd_en   = 1'b0;

    exp_t        exp_q[2][$];
    int          acc_q[2][$];
    bit          has_first[2];
    int          first_cyc[2];
    bit          hold[2];
    logic [31:0] hold_data[2];

    always #5 clk = ~clk;

    shift_rot_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_data   (in_data8),
        .in_amt    (in_amt8),
        .in_mode   (in_mode8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_data  (out_data8)
    );

    shift_rot_seq #(.WIDTH(32)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_data   (in_data32),
        .in_amt    (in_amt32),
        .in_mode   (in_mode32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_data  (out_data32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [31:0] d, input int amt, input logic [1:0] m);
        logic [31:0] r = d;
        for (int i = 0; i < amt; i++) begin
            case (m)
                MODE_ROL: r = {r[30:0], r[31]};
                MODE_ROR: r = {r[0], r[31:1]};
                MODE_SLL: r = {r[30:0], 1'b0};
                default:  r = {1'b0, r[31:1]};
            endcase
        end
        return r;
    endfunction

    // Called once per cycle, between edges; acc/ov/ordy describe the coming edge.
    task automatic mon(input int u, input bit rst_s, input bit acc, input bit ov,
                       input bit ordy, input logic [31:0] od);
        exp_t e;
        int   a;
        if (rst_s) begin
            acc_q[u].delete();
            has_first[u] = 1'b0;
            hold[u]      = 1'b0;
            return;
        end
        if (acc) acc_q[u].push_back(cyc);
        if (hold[u]) begin
            check($sformatf("u%0d_hold_valid", u), {31'd0, ov}, 32'd1);
            check($sformatf("u%0d_hold_data", u), od, hold_data[u]);
        end
        if (ov && !has_first[u]) begin
            has_first[u] = 1'b1;
            first_cyc[u] = cyc;
        end
        if (ov && ordy) begin
            if (exp_q[u].size() == 0) begin
                check($sformatf("u%0d_unexpected_output", u), od, 32'hDEAD_BEEF);
            end else begin
                e = exp_q[u].pop_front();
                check($sformatf("u%0d_data", u), od, e.data);
                if (acc_q[u].size() != 0) begin
                    a = acc_q[u].pop_front();
                    check($sformatf("u%0d_latency", u), 32'(first_cyc[u] - a), 32'(e.amt + 1));
                end else begin
                    check($sformatf("u%0d_missing_accept", u), 32'd0, 32'd1);
                end
            end
            has_first[u] = 1'b0;
            hold[u]      = 1'b0;
        end else if (ov) begin
            hold[u]      = 1'b1;
            hold_data[u] = od;
        end else begin
            hold[u] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            mon(0, rst, in_valid8 && in_ready8, out_valid8, out_ready8, 32'(out_data8));
            mon(1, rst, in_valid32 && in_ready32, out_valid32, out_ready32, out_data32);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            out_ready32 = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Returns at the falling edge after the accepting rising edge, with in_valid dropped.
    task automatic issue8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                          input bit push, input logic [7:0] expd);
        bit ok = 1'b0;
        exp_t e;
        @(negedge clk);
        if (push) begin
            e.data = 32'(expd);
            e.amt  = int'(a);
            exp_q[0].push_back(e);
        end
        in_valid8 = 1'b1; in_data8 = d; in_amt8 = a; in_mode8 = m;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready8) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid8 = 1'b0;
        check("accept8_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic issue32(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m);
        bit ok = 1'b0;
        exp_t e;
        @(negedge clk);
        e.data = ref32(d, int'(a), m);
        e.amt  = int'(a);
        exp_q[1].push_back(e);
        in_valid32 = 1'b1; in_data32 = d; in_amt32 = a; in_mode32 = m;
        for (int i = 0; i < 500; i++) begin
            #1;
            if (in_ready32) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid32 = 1'b0;
        check("accept32_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic drain(input int u);
        for (int i = 0; i < 5000; i++) begin
            if (exp_q[u].size() == 0) break;
            @(negedge clk);
        end
        check($sformatf("u%0d_drain_timeout", u), 32'(exp_q[u].size()), 32'd0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
        in_valid32 = 1'b0; in_data32 = '0; in_amt32 = '0; in_mode32 = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid8}, 32'd0);
        check("reset_out_data", 32'(out_data8), 32'd0);
        check("reset_in_ready", {31'd0, in_ready8}, 32'd1);
        check("reset_in_ready32", {31'd0, in_ready32}, 32'd1);

        issue8(8'h81, 3'd1, MODE_ROL, 1'b1, 8'h03);
        drain(0);
        issue8(8'h81, 3'd3, MODE_ROR, 1'b1, 8'h30);
        issue8(8'hFF, 3'd7, MODE_SLL, 1'b1, 8'h80);
        issue8(8'hFF, 3'd7, MODE_SRL, 1'b1, 8'h01);
        drain(0);

        // Zero amount: result next cycle, no new accept until the output is taken.
        @(negedge clk);
        out_ready8 = 1'b0;
        issue8(8'hA5, 3'd0, MODE_ROR, 1'b1, 8'hA5);
        repeat (3) begin
            #1;
            check("amt0_in_ready_low", {31'd0, in_ready8}, 32'd0);
            check("amt0_out_valid", {31'd0, out_valid8}, 32'd1);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        drain(0);

        // Backpressure with a second request held by the producer.
        @(negedge clk);
        out_ready8 = 1'b0;
        issue8(8'h12, 3'd2, MODE_ROL, 1'b1, 8'h48);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (out_valid8) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("bp_out_valid_timeout", {31'd0, ok}, 32'd1);
        @(negedge clk);
        begin
            exp_t e;
            e.data = 32'h08;
            e.amt  = 4;
            exp_q[0].push_back(e);
        end
        in_valid8 = 1'b1; in_data8 = 8'h80; in_amt8 = 3'd4; in_mode8 = MODE_SRL;
        repeat (5) begin
            #1;
            check("bp_no_accept", {31'd0, in_ready8}, 32'd0);
            @(negedge clk);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        #1;
        check("bp_in_ready_back", {31'd0, in_ready8}, 32'd1);
        @(negedge clk);
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        drain(0);

        // Reset mid-BUSY drops the transaction.
        issue8(8'h01, 3'd6, MODE_ROL, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid8}, 32'd0);
        check("midrst_out_data", 32'(out_data8), 32'd0);
        check("midrst_in_ready", {31'd0, in_ready8}, 32'd1);
        ok = 1'b0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (out_valid8) ok = 1'b1;
        end
        check("midrst_no_stale", {31'd0, ok}, 32'd0);

        // WIDTH=32 regression with random backpressure.
        rnd_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            issue32($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
        end
        drain(1);
        rnd_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, actual %0d cycles, required fewer", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
